// File: rtl/fifo_sched_ctrl_pkg.sv
// Shared encodings for the FIFO drain scheduler: FSM states, default geometry, sink index.
package fc_sched_pkg;

  localparam int unsigned FIFO_COUNT_DEF = 5;
  localparam int unsigned DATA_WIDTH_DEF = 6;
  localparam int unsigned SINK_IDX       = FIFO_COUNT_DEF - 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_ERROR  = 2'd3
  } sched_state_e;

  // The sink is always the highest-numbered FIFO.
  function automatic int unsigned sink_index(input int unsigned fifo_count);
    return fifo_count - 1;
  endfunction

endpackage

// File: rtl/fifo_sched_ctrl_rr_arbiter.sv
// Round-robin picker: one-hot grant searching from last_grant+1, pointer advances on a grant.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] last_grant
);

  logic [PW-1:0] idx;
  logic [PW-1:0] pick;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    pick  = last_grant;
    idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = PW'((32'(last_grant) + k) % N);
      if (enable && !found && req[idx]) begin
        grant[idx] = 1'b1;
        pick       = idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= PW'(N - 1);
    end else if (found) begin
      last_grant <= pick;
    end
  end

endmodule

// File: rtl/fifo_sched_ctrl.sv
// Drains source FIFOs round-robin into one sink FIFO with pause hysteresis and sticky overflow error.
module fifo_sched_ctrl
  import fc_sched_pkg::*;
#(
  parameter int unsigned FIFO_COUNT = FIFO_COUNT_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enb,
  input  logic [FIFO_COUNT-1:0]                almost_full_in,
  input  logic [FIFO_COUNT-1:0]                full_in,
  input  logic [FIFO_COUNT-1:0]                almost_empty_in,
  input  logic [FIFO_COUNT-1:0]                empty_in,
  input  logic [FIFO_COUNT-2:0]                continuar,
  input  logic [(FIFO_COUNT-1)*DATA_WIDTH-1:0] src_data,
  output logic [FIFO_COUNT-2:0]                pop,
  output logic                                 push,
  output logic [DATA_WIDTH-1:0]                sink_data,
  output logic [1:0]                           state,
  output logic                                 idle,
  output logic                                 error
);

  localparam int unsigned NS   = FIFO_COUNT - 1;
  localparam int unsigned SINK = sink_index(FIFO_COUNT);
  localparam int unsigned PW   = (NS > 1) ? $clog2(NS) : 1;

  sched_state_e          state_q, state_d;
  logic                  sink_pause;
  logic [NS-1:0]         eligible;
  logic                  any_elig;
  logic                  grant_ok;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [PW-1:0]         rr_last;
  logic                  unused_bits;

  assign eligible = ~empty_in[NS-1:0] & continuar;
  assign any_elig = |eligible;
  assign grant_ok = (state_q == ST_ACTIVE) && enb && !sink_pause && !full_in[SINK];
  assign overflow = push && full_in[SINK];
  assign state    = state_q;

  // Source-side level flags and the arbiter pointer are not needed by the scheduler itself.
  assign unused_bits = ^{almost_full_in[NS-1:0], full_in[NS-1:0],
                         almost_empty_in[NS-1:0], empty_in[SINK], rr_last};

  rr_arbiter #(.N(NS)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        (eligible),
    .enable     (grant_ok),
    .grant      (pop),
    .last_grant (rr_last)
  );

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      if (pop[i]) sel_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Set on almost-full, release on almost-empty; set wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sink_pause <= 1'b0;
    end else if (almost_full_in[SINK]) begin
      sink_pause <= 1'b1;
    end else if (almost_empty_in[SINK]) begin
      sink_pause <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (enb && any_elig && !sink_pause) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (sink_pause)             state_d = ST_PAUSE;
        else if (!any_elig || !enb) state_d = ST_IDLE;
      end
      ST_PAUSE:  if (!sink_pause) state_d = ST_IDLE;
      default:   state_d = ST_ERROR;
    endcase
    if (overflow) state_d = ST_ERROR;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      push      <= 1'b0;
      sink_data <= '0;
      error     <= 1'b0;
      idle      <= 1'b1;
    end else begin
      state_q <= state_d;
      push    <= |pop;
      if (|pop) sink_data <= sel_data;
      error   <= error | overflow;
      idle    <= (state_d == ST_IDLE) && !(|pop);
    end
  end

endmodule

// File: tb/tb_fifo_sched_ctrl.sv
// Bench for fifo_sched_ctrl: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_fifo_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enb;
  logic [4:0]  af, fu, ae, em;
  logic [3:0]  cont;
  logic [23:0] sdata;

  logic [3:0]  pop;
  logic        push;
  logic [5:0]  sink_data;
  logic [1:0]  state;
  logic        idle;
  logic        error;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_state, m_last;
  bit         m_pause, m_push, m_err, m_idle;
  logic [5:0] m_data;

  always #5 clk = ~clk;

  fifo_sched_ctrl #(.FIFO_COUNT(5), .DATA_WIDTH(6)) dut (
    .clk             (clk),
    .rst             (rst),
    .enb             (enb),
    .almost_full_in  (af),
    .full_in         (fu),
    .almost_empty_in (ae),
    .empty_in        (em),
    .continuar       (cont),
    .src_data        (sdata),
    .pop             (pop),
    .push            (push),
    .sink_data       (sink_data),
    .state           (state),
    .idle            (idle),
    .error           (error)
  );

  function automatic logic [3:0] exp_pop();
    logic [3:0] r;
    r = '0;
    if (m_state == 1 && enb && !m_pause && !fu[4]) begin
      for (int k = 1; k <= 4; k++) begin
        int j;
        j = (m_last + k) % 4;
        if (r == 4'b0 && !em[j] && cont[j]) r[j] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_state = 0; m_last = 3; m_pause = 0; m_push = 0; m_err = 0; m_idle = 1; m_data = '0;
  endtask

  // Advance model by one clock using the currently driven inputs, then step the DUT.
  task automatic tick();
    logic [3:0] p;
    int ns;
    bit any;
    p   = exp_pop();
    any = |(~em[3:0] & cont);
    ns  = m_state;
    case (m_state)
      0: if (enb && any && !m_pause) ns = 1;
      1: if (m_pause) ns = 2; else if (!any || !enb) ns = 0;
      2: if (!m_pause) ns = 0;
      default: ns = 3;
    endcase
    if (m_push && fu[4]) begin ns = 3; m_err = 1; end
    for (int i = 0; i < 4; i++) if (p[i]) begin m_data = sdata[i*6 +: 6]; m_last = i; end
    if (af[4]) m_pause = 1; else if (ae[4]) m_pause = 0;
    m_push  = (p != 4'b0);
    m_state = ns;
    m_idle  = (ns == 0) && (p == 4'b0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    enb = 0; af = '0; fu = '0; ae = 5'b10000; em = '1; cont = '0; sdata = '0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    enb = 1; em = '0; cont = '1; sdata = 24'hFFFFFF;
    rst = 1'b0; #2;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (pop !== 4'b0) begin errors++; $display("FAIL reset_pop got %b want 0000", pop); end
    checks++; if (push !== 1'b0) begin errors++; $display("FAIL reset_push got %b want 0", push); end
    checks++; if (sink_data !== 6'd0) begin errors++; $display("FAIL reset_data got %h want 00", sink_data); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", idle); end
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_round_robin();
    logic [3:0] seq [3];
    logic [5:0] word;
    int idx;
    seq[0] = 4'b0001; seq[1] = 4'b0100; seq[2] = 4'b0001;
    word = '0;
    do_reset();
    enb = 1; em = 5'b11010; cont = 4'b1111; sdata = $urandom; #1;
    checks++; if ({state, pop} !== 6'b0) begin errors++; $display("FAIL rr_first_idle got %b want 000000", {state, pop}); end
    tick();
    for (int c = 0; c < 4; c++) begin
      sdata = $urandom; #1;
      if (c < 3) begin
        checks++; if (pop !== seq[c]) begin errors++; $display("FAIL rr_pop%0d got %b want %b", c, pop, seq[c]); end
      end
      checks++; if (push !== (c > 0)) begin errors++; $display("FAIL rr_push%0d got %b want %b", c, push, c > 0); end
      if (c > 0) begin
        checks++; if (sink_data !== word) begin errors++; $display("FAIL rr_data%0d got %h want %h", c, sink_data, word); end
      end
      if (c < 3) begin
        idx  = (seq[c] == 4'b0001) ? 0 : 2;
        word = sdata[idx*6 +: 6];
      end
      tick();
    end
  endtask

  task automatic test_mask_and_pause();
    logic [3:0] seq [4];
    seq[0] = 4'b0001; seq[1] = 4'b0100; seq[2] = 4'b1000; seq[3] = 4'b0001;
    do_reset();
    enb = 1; em = 5'b10000; cont = 4'b1101; #1;
    tick();
    for (int c = 0; c < 4; c++) begin
      sdata = $urandom; #1;
      checks++; if (pop !== seq[c]) begin errors++; $display("FAIL mask_pop%0d got %b want %b", c, pop, seq[c]); end
      tick();
    end
    af = 5'b10000; ae = 5'b00000; #1;
    checks++; if (pop !== 4'b0100) begin errors++; $display("FAIL pause_last_pop got %b want 0100", pop); end
    tick(); #1;
    checks++; if ({state, pop} !== {2'd1, 4'b0}) begin errors++; $display("FAIL pause_block got st=%0d pop=%b want st=1 pop=0000", state, pop); end
    tick(); af = 5'b0; #1;
    checks++; if ({state, pop} !== {2'd2, 4'b0}) begin errors++; $display("FAIL pause_state got st=%0d pop=%b want st=2 pop=0000", state, pop); end
    tick(); ae = 5'b10000; #1;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL pause_hold got %0d want 2", state); end
    tick(); #1;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL pause_release_lat got %0d want 2", state); end
    tick(); #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL pause_to_idle got %0d want 0", state); end
    tick(); #1;
    checks++; if ({state, pop} !== {2'd1, 4'b1000}) begin errors++; $display("FAIL pause_resume got st=%0d pop=%b want st=1 pop=1000", state, pop); end
    tick();
  endtask

  task automatic test_error();
    do_reset();
    enb = 1; em = 5'b11110; cont = 4'b1111; #1;
    tick(); #1;
    checks++; if (pop !== 4'b0001) begin errors++; $display("FAIL err_pop got %b want 0001", pop); end
    tick(); fu = 5'b10000; #1;
    checks++; if ({push, pop} !== 5'b10000) begin errors++; $display("FAIL err_setup got push=%b pop=%b want push=1 pop=0000", push, pop); end
    tick(); fu = 5'b0; #1;
    checks++; if ({state, error} !== 3'b111) begin errors++; $display("FAIL err_enter got st=%0d err=%b want st=3 err=1", state, error); end
    tick(); tick(); #1;
    checks++; if ({state, error, pop, push} !== {2'd3, 1'b1, 4'b0, 1'b0}) begin
      errors++; $display("FAIL err_sticky got st=%0d err=%b pop=%b push=%b want 3 1 0000 0", state, error, pop, push);
    end
    rst = 1'b0; #1;
    checks++; if ({state, error} !== 3'b000) begin errors++; $display("FAIL err_clear got st=%0d err=%b want 0 0", state, error); end
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_enb_drop();
    logic [5:0] word;
    do_reset();
    enb = 1; em = 5'b11110; cont = 4'b1111; #1;
    tick(); sdata = $urandom; #1;
    word = sdata[5:0];
    checks++; if (pop !== 4'b0001) begin errors++; $display("FAIL enb_pop got %b want 0001", pop); end
    tick(); enb = 0; #1;
    checks++; if ({push, sink_data, pop, state} !== {1'b1, word, 4'b0, 2'd1}) begin
      errors++; $display("FAIL enb_push got push=%b data=%h pop=%b st=%0d want 1 %h 0000 1", push, sink_data, pop, state, word);
    end
    tick(); #1;
    checks++; if ({state, idle, push} !== {2'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL enb_idle got st=%0d idle=%b push=%b want 0 1 0", state, idle, push);
    end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    enb = 1; em = 5'b11110; cont = 4'b1111; sdata = {4{6'b101011}}; #1;
    tick(); tick(); #1;
    checks++; if ({push, sink_data} !== {1'b1, 6'b101011}) begin errors++; $display("FAIL arst_pending got push=%b data=%h want 1 2b", push, sink_data); end
    #2 rst = 1'b0; #1;
    checks++; if ({push, pop, sink_data, state} !== 13'b0) begin
      errors++; $display("FAIL arst_clear got push=%b pop=%b data=%h st=%0d want all 0", push, pop, sink_data, state);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    logic [3:0] ep;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      enb   = ($urandom % 10) != 0;
      em    = 5'($urandom);
      cont  = 4'($urandom);
      af    = (($urandom % 8) == 0) ? 5'b10000 : 5'b0;
      ae    = (($urandom % 4) == 0) ? 5'b10000 : 5'b0;
      fu    = '0;
      sdata = 24'($urandom);
      #1;
      ep = exp_pop();
      checks++; if (pop !== ep) begin errors++; $display("FAIL rnd_pop c%0d got %b want %b", c, pop, ep); end
      checks++; if (push !== m_push) begin errors++; $display("FAIL rnd_push c%0d got %b want %b", c, push, m_push); end
      checks++; if (state !== 2'(m_state)) begin errors++; $display("FAIL rnd_state c%0d got %0d want %0d", c, state, m_state); end
      checks++; if ({idle, error} !== {m_idle, m_err}) begin errors++; $display("FAIL rnd_flags c%0d got %b%b want %b%b", c, idle, error, m_idle, m_err); end
      if (m_push) begin
        checks++; if (sink_data !== m_data) begin errors++; $display("FAIL rnd_data c%0d got %h want %h", c, sink_data, m_data); end
      end
      tick();
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_round_robin();
    test_mask_and_pause();
    test_error();
    test_enb_drop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
